// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: ifetch vs load/store with registered responses and a low-memory dump engine.
// Define MEM_ARB_RR_EN for round-robin contention handling instead of data priority with starvation guard.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DUMP_WORDS   = 15,
  parameter int unsigned IDX_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [31:0]      i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [2:0]       d_wtype,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  input  logic             dump_start,
  output logic             dump_busy,
  output logic             dump_valid,
  output logic [IDX_W-1:0] dump_idx,
  output logic [31:0]      dump_data,
  output logic             dump_done,
  output logic             mem_we,
  output logic [2:0]       mem_wtype,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DUMP_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    DUMP = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              i_gnt_s, d_gnt_s;
  logic              i_rvalid_q, i_rvalid_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              dump_valid_q, dump_valid_d;
  logic [IDX_W-1:0]  dump_idx_q, dump_idx_d;
  logic [31:0]       dump_data_q, dump_data_d;
  logic              dump_done_q, dump_done_d;
`ifdef MEM_ARB_RR_EN
  logic              last_i_q, last_i_d;
`endif

  // Arbitration, dump sequencing and memory address selection
  always_comb begin
    i_gnt_s    = 1'b0;
    d_gnt_s    = 1'b0;
    state_d    = state_q;
    idx_d      = idx_q;
    mem_addr_d = mem_addr_q;
`ifdef MEM_ARB_RR_EN
    last_i_d   = last_i_q;
`endif
    case (state_q)
      ARB: begin
        if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
          // last_i_q resets high so the first contention goes to data
          if (last_i_q) begin
            d_gnt_s = 1'b1;
          end else begin
            i_gnt_s = 1'b1;
          end
          last_i_d = ~last_i_q;
`else
          if (starve_q == STARVE_MAX) begin
            i_gnt_s = 1'b1;
          end else begin
            d_gnt_s = 1'b1;
          end
`endif
        end else if (i_req) begin
          i_gnt_s = 1'b1;
        end else if (d_req) begin
          d_gnt_s = 1'b1;
        end else begin
          i_gnt_s = 1'b0;
          d_gnt_s = 1'b0;
        end
        if (i_gnt_s) begin
          mem_addr_d = i_addr;
        end else if (d_gnt_s) begin
          mem_addr_d = d_addr;
        end else begin
          mem_addr_d = mem_addr_q;
        end
        if (dump_start) begin
          state_d = DUMP;
        end else begin
          state_d = ARB;
        end
      end
      DUMP: begin
        mem_addr_d = 32'({idx_q, 2'b00});
        if (idx_q == LAST_IDX) begin
          state_d = ARB;
          idx_d   = '0;
        end else begin
          state_d = DUMP;
          idx_d   = idx_q + IDX_ONE;
        end
      end
      default: begin
        state_d = ARB;
        idx_d   = '0;
      end
    endcase
  end

  // Starvation counter: counts lost contention cycles of ifetch
  always_comb begin
    starve_d = starve_q;
`ifdef MEM_ARB_RR_EN
    starve_d = '0;
`else
    if (i_gnt_s || !i_req) begin
      starve_d = '0;
    end else if (state_q == ARB && d_req) begin
      if (starve_q == STARVE_MAX) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + CNT_ONE;
      end
    end else begin
      starve_d = starve_q;
    end
`endif
  end

  // Next values of registered responses and dump outputs
  always_comb begin
    i_rvalid_d   = i_gnt_s;
    d_rvalid_d   = d_gnt_s;
    i_rdata_d    = i_gnt_s ? mem_rdata : i_rdata_q;
    d_rdata_d    = d_gnt_s ? mem_rdata : d_rdata_q;
    dump_valid_d = 1'b0;
    dump_done_d  = 1'b0;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;
    if (state_q == DUMP) begin
      dump_valid_d = 1'b1;
      dump_done_d  = (idx_q == LAST_IDX);
      dump_idx_d   = idx_q;
      dump_data_d  = mem_rdata;
    end else begin
      dump_valid_d = 1'b0;
      dump_done_d  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      starve_q     <= '0;
      idx_q        <= '0;
      mem_addr_q   <= 32'h0000_0000;
      i_rvalid_q   <= 1'b0;
      i_rdata_q    <= 32'h0000_0000;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= 32'h0000_0000;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_data_q  <= 32'h0000_0000;
      dump_done_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_i_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      idx_q        <= idx_d;
      mem_addr_q   <= mem_addr_d;
      i_rvalid_q   <= i_rvalid_d;
      i_rdata_q    <= i_rdata_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
      dump_done_q  <= dump_done_d;
`ifdef MEM_ARB_RR_EN
      last_i_q     <= last_i_d;
`endif
    end
  end

  assign i_gnt      = i_gnt_s;
  assign d_gnt      = d_gnt_s;
  assign i_rvalid   = i_rvalid_q;
  assign i_rdata    = i_rdata_q;
  assign d_rvalid   = d_rvalid_q;
  assign d_rdata    = d_rdata_q;
  assign dump_busy  = (state_q == DUMP);
  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_data_q;
  assign dump_done  = dump_done_q;
  assign mem_we     = d_gnt_s & d_we;
  assign mem_wtype  = d_gnt_s ? d_wtype : 3'b000;
  assign mem_wdata  = d_gnt_s ? d_wdata : 32'h0000_0000;
  assign mem_addr   = mem_addr_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural single-port memory.
// Build with MEM_ARB_RR_EN defined to check the round-robin contention pattern.
module tb_mem_arbiter;
  localparam int DW = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, dump_start;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [2:0]  d_wtype;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        dump_busy, dump_valid, dump_done;
  logic [15:0] dump_idx;
  logic [31:0] dump_data;
  logic        mem_we;
  logic [2:0]  mem_wtype;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];

  mem_arbiter #(.STARVE_LIMIT(4), .DUMP_WORDS(DW), .IDX_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wtype(d_wtype), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done),
    .mem_we(mem_we), .mem_wtype(mem_wtype), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [47:0] dumpq[$];
  bit exp_irv, exp_drv, exp_dv;
  logic [31:0] last_i, last_d;
  int dump_left, done_seen, dump_pulses;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    iq.delete(); dq.delete(); dumpq.delete();
    exp_irv = 1'b0; exp_drv = 1'b0; exp_dv = 1'b0;
    last_i = 32'h0; last_d = 32'h0;
    dump_left = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_i_gnt"}, i_gnt, 1'b0);
    check_val({tag, "_d_gnt"}, d_gnt, 1'b0);
    check_val({tag, "_i_rv"}, {i_rvalid, i_rdata}, 33'h0);
    check_val({tag, "_d_rv"}, {d_rvalid, d_rdata}, 33'h0);
    check_val({tag, "_dump"}, {dump_busy, dump_valid, dump_done, dump_idx, dump_data}, 51'h0);
    check_val({tag, "_mem"}, {mem_we, mem_wtype, mem_addr, mem_wdata}, 68'h0);
  endtask

  // One clock cycle: check last cycle's responses, this cycle's grants, then let the edge happen
  task automatic cycle(input bit eig, input bit edg);
    logic [31:0] w;
    logic [47:0] e;
    int idx;
    logic        pwe;
    logic [31:0] paddr, pdata;
    @(negedge clk);
    check_val("i_rvalid", i_rvalid, exp_irv);
    if (exp_irv) begin
      w = iq.pop_front(); last_i = w;
      if (i_rvalid) check_val("i_rdata", i_rdata, w);
    end else check_val("i_rdata_hold", i_rdata, last_i);
    check_val("d_rvalid", d_rvalid, exp_drv);
    if (exp_drv) begin
      w = dq.pop_front(); last_d = w;
      if (d_rvalid) check_val("d_rdata", d_rdata, w);
    end else check_val("d_rdata_hold", d_rdata, last_d);
    check_val("dump_valid", dump_valid, exp_dv);
    if (exp_dv) begin
      e = dumpq.pop_front();
      if (dump_valid) begin
        dump_pulses++;
        check_val("dump_idx", dump_idx, e[47:32]);
        check_val("dump_data", dump_data, e[31:0]);
        check_val("dump_done", dump_done, e[47:32] == 16'(DW - 1));
      end
    end
    if (dump_done) done_seen++;
    check_val("dump_busy", dump_busy, dump_left > 0);
    check_val("i_gnt", i_gnt, eig);
    check_val("d_gnt", d_gnt, edg);
    exp_irv = eig; exp_drv = edg; exp_dv = (dump_left > 0);
    if (eig) begin
      iq.push_back(mem[i_addr[7:2]]);
      check_val("mem_addr_i", mem_addr, i_addr);
    end
    if (edg) begin
      dq.push_back(mem[d_addr[7:2]]);
      check_val("mem_addr_d", mem_addr, d_addr);
      check_val("mem_we", mem_we, d_we);
      if (d_we) check_val("mem_wr", {mem_wtype, mem_wdata}, {d_wtype, d_wdata});
    end
    if (dump_left > 0) begin
      idx = DW - dump_left;
      dumpq.push_back({idx[15:0], mem[idx]});
      check_val("dump_addr", mem_addr, 64'(idx * 4));
      check_val("dump_we", mem_we, 1'b0);
      dump_left--;
    end else if (dump_start) begin
      dump_left = DW;
    end
    pwe = mem_we; paddr = mem_addr; pdata = mem_wdata;
    @(posedge clk);
    #1;
    if (pwe) mem[paddr[7:2]] = pdata;
  endtask

  int done_before, pulses_before;
  logic [9:0] pat;

  initial begin
    rst_n = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; dump_start = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_wtype = 3'b000;
    for (int k = 0; k < 64; k++) mem[k] = 32'(k);
    mem[2] = 32'hDEAD_BEEF;
    mem[4] = 32'hA5A5_0004;
    clear_model();
    done_seen = 0; dump_pulses = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // ifetch only
    i_req = 1'b1; i_addr = 32'h8;
    cycle(1'b1, 1'b0);
    i_req = 1'b0;
    cycle(1'b0, 1'b0);
    check_val("ifetch_word", last_i, 32'hDEAD_BEEF);

    // store then load of the same word
    d_req = 1'b1; d_we = 1'b1; d_wtype = 3'b010; d_addr = 32'h10; d_wdata = 32'h1234_5678;
    cycle(1'b0, 1'b1);
    d_we = 1'b0;
    cycle(1'b0, 1'b1);
    d_req = 1'b0;
    cycle(1'b0, 1'b0);
    check_val("load_after_store", last_d, 32'h1234_5678);

    // contention for 10 cycles; bit k set means ifetch wins cycle k
`ifdef MEM_ARB_RR_EN
    pat = 10'b1010101010;
`else
    pat = 10'b1000010000;
`endif
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0C; d_addr = 32'h14;
    for (int k = 0; k < 10; k++) cycle(pat[k], !pat[k]);
    i_req = 1'b0; d_req = 1'b0;
    cycle(1'b0, 1'b0);

    // dump of words 0..14 with requests held during the dump
    for (int k = 0; k < 64; k++) mem[k] = 32'(k);
    done_before = done_seen; pulses_before = dump_pulses;
    dump_start = 1'b1;
    cycle(1'b0, 1'b0);
    dump_start = 1'b0; i_req = 1'b1; d_req = 1'b1; d_addr = 32'h18;
    for (int k = 0; k < DW; k++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    i_req = 1'b0; d_req = 1'b0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_val("dump1_pulses", dump_pulses - pulses_before, DW);
    check_val("dump1_done", done_seen - done_before, 1);

    // dump_start with a coincident write, plus a second start pulse mid-dump
    done_before = done_seen; pulses_before = dump_pulses;
    dump_start = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D;
    cycle(1'b0, 1'b1);
    dump_start = 1'b0; d_req = 1'b0; d_we = 1'b0;
    for (int k = 0; k < DW; k++) begin
      dump_start = (k == 3);
      cycle(1'b0, 1'b0);
    end
    dump_start = 1'b0;
    repeat (3) cycle(1'b0, 1'b0);
    check_val("wr_commit", mem[16], 32'hCAFE_F00D);
    check_val("dump2_pulses", dump_pulses - pulses_before, DW);
    check_val("dump2_done", done_seen - done_before, 1);

    // reset in the middle of a dump
    done_before = done_seen;
    dump_start = 1'b1;
    cycle(1'b0, 1'b0);
    dump_start = 1'b0;
    repeat (5) cycle(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_dump_rst");
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) cycle(1'b0, 1'b0);
    check_val("no_done_after_abort", done_seen, done_before);
    mem[2] = 32'hDEAD_BEEF;
    i_req = 1'b1; i_addr = 32'h8;
    cycle(1'b1, 1'b0);
    i_req = 1'b0;
    cycle(1'b0, 1'b0);
    check_val("ifetch_after_rst", last_i, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
